imem_loader_ctrl: RTL and testbench
===================================

Name: imem_loader_ctrl

Overview:
- Sequences instruction-memory programming for the FETCH stage on behalf of the debug unit.
- Accepts a byte stream from the UART receiver and assembles big-endian 32-bit instruction words.
- Drives the fetch-stage debug address mux, imem write/read enables, write address/data and the fetch stall line.
- Terminates on the HALT instruction and releases the pipeline on command.

Parameters:
- NB_INST, 32, instruction width (multiple of NB_BYTE)
- NB_ADDR, `ADDRWIDTH, imem write-address width
- MEM_SIZEB, `N_ELEMENTS, imem capacity in bytes
- NB_BYTE, 8, receive byte width
- ADDR_STEP, 4, address increment per written word
- HALT_INST, 32'hFC000000, end-of-program opcode word

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  one-cycle pulse: begin loading at address 0
- i_run  in  1  one-cycle pulse: release pipeline after load completes
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  i_rx_data valid this cycle; no backpressure
- o_debug_unit  out  1  selects o_wr_addr as the imem address
- o_mem_wen  out  1  imem write enable
- o_mem_ren  out  1  imem read enable
- o_wr_addr  out  NB_ADDR  imem write address
- o_mem_data  out  NB_INST  imem write data
- o_fetch_stall  out  1  high means fetch is disabled (PC and imem hold)
- o_load_done  out  1  program loaded with HALT seen
- o_error  out  1  capacity overflow or checksum failure
- o_inst_count  out  NB_ADDR  number of words written

Behaviour:
- Reset values:
  - o_mem_ren=1.
  - All other outputs 0.
  - State IDLE, byte counter 0, address register 0.
- A partial word in progress is discarded on reset.
- States: IDLE, RECV, WRITE, DONE, ERROR (plus CHK with the optional feature).
- IDLE:
  - o_fetch_stall=0, o_debug_unit=0.
  - i_start -> RECV next cycle. Address, count, byte counter, o_load_done and o_error are cleared on that edge.
  - i_rx_valid is ignored in IDLE.
- RECV:
  - o_fetch_stall=1, o_debug_unit=1, o_mem_ren=0.
  - Each i_rx_valid cycle shifts the byte in; the first byte is the MSB.
  - When the 4th byte is accepted, the word is copied to o_mem_data and the state goes to WRITE.
- WRITE (exactly one cycle):
  - o_mem_wen=1, with o_wr_addr equal to the current address and o_mem_data stable.
  - On exit: address += ADDR_STEP (wraps modulo 2^NB_ADDR) and o_inst_count += 1.
  - A byte arriving during WRITE is accepted into the assembly register, so no bytes are lost. Minimum throughput is one byte per cycle.
- WRITE exit priority:
  1. Word == HALT_INST -> DONE. The HALT word itself is written.
  2. Otherwise o_inst_count (post-increment) == MEM_SIZEB/ADDR_STEP -> ERROR.
  3. Otherwise -> RECV.
- DONE:
  - o_load_done=1, o_fetch_stall=1, o_debug_unit=0, o_mem_ren=1.
  - i_run -> IDLE. o_load_done stays 1 in IDLE until the next i_start.
  - Bytes are ignored.
- ERROR:
  - o_error=1, o_fetch_stall=1, o_debug_unit=0, o_mem_wen=0.
  - Left only by i_reset or i_start; i_start restarts from address 0.
- i_start in RECV/WRITE/DONE is ignored. i_run outside DONE is ignored.
- Simultaneous i_start and i_reset: reset wins.
- o_mem_wen is never high outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of every received byte is kept; it is cleared on i_start.
  - After the HALT word is written, the state goes to CHK instead of DONE.
  - CHK waits for one more byte. Equal to the XOR of all preceding bytes -> DONE; otherwise -> ERROR.
  - CHK outputs match DONE except o_load_done=0.
- Disabled: no CHK state, no XOR register; HALT goes directly to DONE.

Test Plan:
- Reset, then idle 5 cycles -> o_mem_ren=1; all other outputs 0; o_fetch_stall=0.
- i_start, then bytes 20 01 00 05, FC 00 00 00 -> two o_mem_wen pulses:
  - addr 0, data 32'h20010005
  - addr 4, data 32'hFC000000
  - then o_load_done=1, o_inst_count=2, stall=1; i_run -> stall=0.
- Back-to-back bytes every cycle (8 bytes, incl. a byte during WRITE) -> both words written correctly, no byte dropped.
- MEM_SIZEB=16, stream 4 non-HALT words -> 4 writes (addr 0,4,8,12), then o_error=1, stall=1; i_start recovers from addr 0.
- i_reset after 2 bytes of a word, then i_start and a full HALT word -> single write of 32'hFC000000 at addr 0; no stale bytes.
- With IMEM_LOADER_CHECKSUM_EN:
  - HALT word then checksum byte FC -> DONE.
  - Checksum byte 00 -> o_error=1.

Source files
------------

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: assembles big-endian instruction words from a UART byte
// stream and writes them into the fetch-stage instruction memory while the
// pipeline is stalled. Loading ends on the HALT word; i_run releases fetch.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the load is reported done.

`ifndef ADDRWIDTH
`define ADDRWIDTH 10
`endif
`ifndef N_ELEMENTS
`define N_ELEMENTS 1024
`endif

module imem_loader_ctrl #(
  parameter int unsigned NB_INST   = 32,
  parameter int unsigned NB_ADDR   = `ADDRWIDTH,
  parameter int unsigned MEM_SIZEB = `N_ELEMENTS,
  parameter int unsigned NB_BYTE   = 8,
  parameter int unsigned ADDR_STEP = 4,
  parameter logic [NB_INST-1:0] HALT_INST = 32'hFC000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_run,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_debug_unit,
  output logic               o_mem_wen,
  output logic               o_mem_ren,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_INST-1:0] o_mem_data,
  output logic               o_fetch_stall,
  output logic               o_load_done,
  output logic               o_error,
  output logic [NB_ADDR-1:0] o_inst_count
);

  localparam int unsigned BYTES_PER_WORD = NB_INST / NB_BYTE;
  localparam int unsigned NB_BCNT = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_ADDR-1:0] MAX_WORDS = NB_ADDR'(MEM_SIZEB / ADDR_STEP);
  localparam logic [NB_ADDR-1:0] STEP      = NB_ADDR'(ADDR_STEP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHK
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [NB_BCNT-1:0]   bcnt_q, bcnt_d;
  logic [NB_INST-1:0]   asm_q, asm_d;
  logic [NB_INST-1:0]   data_q, data_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic [NB_ADDR-1:0]   count_q, count_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 stall_q, stall_d;
  logic                 debug_q, debug_d;
  logic                 wen_q, wen_d;
  logic                 ren_q, ren_d;
  logic [NB_INST-1:0]   word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]   xor_q, xor_d;
`endif

  assign word_next = {asm_q[NB_INST-NB_BYTE-1:0], i_rx_data};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (i_start) begin
          state_d = ST_RECV;
          bcnt_d  = '0;
          addr_d  = '0;
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      ST_RECV: begin
        if (i_rx_valid) begin
          asm_d = word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ i_rx_data;
`endif
          if (bcnt_q == LAST_BYTE) begin
            data_d  = word_next;
            bcnt_d  = '0;
            state_d = ST_WRITE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + STEP;
        count_d = count_q + 1'b1;
        // The byte counter is always zero here, so a byte landing in the
        // write cycle simply becomes byte 0 of the next word.
        if (i_rx_valid) begin
          asm_d  = word_next;
          bcnt_d = bcnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ i_rx_data;
`endif
        end
        if (data_q == HALT_INST) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // A byte arriving in the HALT write cycle is the checksum itself.
          if (i_rx_valid) begin
            state_d = (i_rx_data == xor_q) ? ST_DONE : ST_ERROR;
          end else begin
            state_d = ST_CHK;
          end
`else
          state_d = ST_DONE;
`endif
        end else if (count_d == MAX_WORDS) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (i_rx_valid) begin
          state_d = (i_rx_data == xor_q) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_DONE: begin
        if (i_run) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
    if (state_d == ST_ERROR) begin
      err_d = 1'b1;
    end

    stall_d = (state_d != ST_IDLE);
    debug_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
    wen_d   = (state_d == ST_WRITE);
    ren_d   = !debug_d;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      debug_q <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      debug_q <= debug_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign o_debug_unit  = debug_q;
  assign o_mem_wen     = wen_q;
  assign o_mem_ren     = ren_q;
  assign o_wr_addr     = addr_q;
  assign o_mem_data    = data_q;
  assign o_fetch_stall = stall_q;
  assign o_load_done   = done_q;
  assign o_error       = err_q;
  assign o_inst_count  = count_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Testbench for imem_loader_ctrl: expected imem writes are queued by the
// stimulus process and popped by a monitor on every o_mem_wen cycle.
// Checksum-byte cases run when IMEM_LOADER_CHECKSUM_EN is defined.

module tb_imem_loader_ctrl;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic          run;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          o_debug_unit;
  logic          o_mem_wen;
  logic          o_mem_ren;
  logic [AW-1:0] o_wr_addr;
  logic [31:0]   o_mem_data;
  logic          o_fetch_stall;
  logic          o_load_done;
  logic          o_error;
  logic [AW-1:0] o_inst_count;

  int unsigned vectors;
  int unsigned miscompares;
  logic [AW+31:0] exp_q[$];

  imem_loader_ctrl #(
    .NB_INST  (32),
    .NB_ADDR  (AW),
    .MEM_SIZEB(16),
    .NB_BYTE  (8),
    .ADDR_STEP(4),
    .HALT_INST(32'hFC000000)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_run        (run),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_debug_unit (o_debug_unit),
    .o_mem_wen    (o_mem_wen),
    .o_mem_ren    (o_mem_ren),
    .o_wr_addr    (o_wr_addr),
    .o_mem_data   (o_mem_data),
    .o_fetch_stall(o_fetch_stall),
    .o_load_done  (o_load_done),
    .o_error      (o_error),
    .o_inst_count (o_inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (o_mem_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", o_wr_addr, o_mem_data);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(o_wr_addr), 64'(e[AW+31:32]));
        check("wr_data", 64'(o_mem_data), 64'(e[31:0]));
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_queue_drained(input string name);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    start    = 1'b0;
    run      = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Reset / idle state
    check("rst_ren",   64'(o_mem_ren), 64'd1);
    check("rst_wen",   64'(o_mem_wen), 64'd0);
    check("rst_stall", 64'(o_fetch_stall), 64'd0);
    check("rst_debug", 64'(o_debug_unit), 64'd0);
    check("rst_done",  64'(o_load_done), 64'd0);
    check("rst_error", 64'(o_error), 64'd0);
    check("rst_count", 64'(o_inst_count), 64'd0);
    check("rst_addr",  64'(o_wr_addr), 64'd0);

    // Bytes in IDLE must not be assembled.
    send_byte(8'h55, 1);
    check("idle_stall", 64'(o_fetch_stall), 64'd0);

    // Basic two-word load with gaps between bytes.
    pulse_start();
    check("recv_stall", 64'(o_fetch_stall), 64'd1);
    check("recv_debug", 64'(o_debug_unit), 64'd1);
    check("recv_ren",   64'(o_mem_ren), 64'd0);
    expect_write(AW'(0), 32'h20010005);
    expect_write(AW'(4), 32'hFC000000);
    send_word(32'h20010005, 1);
    send_word(32'hFC000000, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hD8, 1);
`endif
    tick(3);
    check_queue_drained("basic_writes");
    check("basic_done",  64'(o_load_done), 64'd1);
    check("basic_count", 64'(o_inst_count), 64'd2);
    check("basic_stall", 64'(o_fetch_stall), 64'd1);
    check("basic_debug", 64'(o_debug_unit), 64'd0);
    check("basic_ren",   64'(o_mem_ren), 64'd1);
    pulse_run();
    tick(1);
    check("run_stall", 64'(o_fetch_stall), 64'd0);
    check("run_done",  64'(o_load_done), 64'd1);

    // Back-to-back bytes; byte 5 lands in the first write cycle.
    pulse_start();
    check("start_clears_done", 64'(o_load_done), 64'd0);
    expect_write(AW'(0), 32'h11223344);
    expect_write(AW'(4), 32'hFC000000);
    send_word(32'h11223344, 0);
    send_word(32'hFC000000, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hB8, 0);
`endif
    tick(3);
    check_queue_drained("b2b_writes");
    check("b2b_done",  64'(o_load_done), 64'd1);
    check("b2b_count", 64'(o_inst_count), 64'd2);

    // Capacity overflow: 16 bytes of imem hold 4 words.
    pulse_run();
    pulse_start();
    expect_write(AW'(0),  32'h01020304);
    expect_write(AW'(4),  32'h05060708);
    expect_write(AW'(8),  32'h090A0B0C);
    expect_write(AW'(12), 32'h0D0E0F10);
    send_word(32'h01020304, 0);
    send_word(32'h05060708, 0);
    send_word(32'h090A0B0C, 0);
    send_word(32'h0D0E0F10, 0);
    tick(3);
    check_queue_drained("ovf_writes");
    check("ovf_error", 64'(o_error), 64'd1);
    check("ovf_stall", 64'(o_fetch_stall), 64'd1);
    check("ovf_count", 64'(o_inst_count), 64'd4);
    check("ovf_done",  64'(o_load_done), 64'd0);
    send_byte(8'hAA, 1);
    check("ovf_hold_error", 64'(o_error), 64'd1);

    // Recovery from ERROR restarts at address 0.
    pulse_start();
    check("recover_error", 64'(o_error), 64'd0);
    expect_write(AW'(0), 32'hFC000000);
    send_word(32'hFC000000, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hFC, 1);
`endif
    tick(3);
    check_queue_drained("recover_writes");
    check("recover_done", 64'(o_load_done), 64'd1);

    // Reset mid-word discards the partial word.
    pulse_run();
    pulse_start();
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_stall", 64'(o_fetch_stall), 64'd0);
    pulse_start();
    expect_write(AW'(0), 32'hFC000000);
    send_word(32'hFC000000, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hFC, 1);
`endif
    tick(3);
    check_queue_drained("midrst_writes");
    check("midrst_count", 64'(o_inst_count), 64'd1);
    check("midrst_done",  64'(o_load_done), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum byte.
    pulse_run();
    pulse_start();
    expect_write(AW'(0), 32'hFC000000);
    send_word(32'hFC000000, 1);
    tick(2);
    check("chk_wait_done", 64'(o_load_done), 64'd0);
    check("chk_wait_stall", 64'(o_fetch_stall), 64'd1);
    send_byte(8'h00, 1);
    tick(2);
    check_queue_drained("chk_writes");
    check("chk_error", 64'(o_error), 64'd1);
    check("chk_done",  64'(o_load_done), 64'd0);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
